apb_ram_arbiter: RTL and testbench
==================================

Name: apb_ram_arbiter

Overview:
Two-requester APB master that shares the single APB RAM slave (4 KiB window, word-addressed via PADDR[11:2]) between a CPU-side port (req0) and a DMA-side port (req1). It runs a round-robin arbiter and one APB transfer at a time through IDLE/SETUP/ACCESS/DONE phases. It returns a registered done pulse and read data to the granted requester. It sits between the bus decoder/DMA and the RAM's PSEL/PENABLE/PREADY interface.

Parameters:
ADDR_W, 12, APB address width driven on PADDR
DATA_W, 32, APB data width
TIMEOUT, 16, ACCESS-phase cycles without PREADY before abort (used only with the optional feature)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 request, held until req0_done
req0_write  in  1  1=write, 0=read; stable while valid
req0_addr  in  ADDR_W  byte address; stable while valid
req0_wdata  in  DATA_W  write data; stable while valid
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_W  read data, valid while req0_done=1, held afterwards
req0_err  out  1  abort flag, qualified by req0_done
req1_valid, req1_write, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: same as req0 for requester 1
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  APB write data
PSEL  out  1  APB select
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready

Behaviour:
- Clock and reset: PCLK is the only clock. Reset is asynchronous and active-low on PRESETn. Both are fixed.
- Reset: state=IDLE and last_grant=1, so req0 wins first. All outputs go to 0 immediately, including PSEL, PENABLE, PADDR, PWDATA, PWRITE, reqN_done, reqN_rdata and reqN_err.
- Reset mid-transfer: the transfer is dropped, no done is issued, and the requester must re-request.
- All outputs are registered.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the port not equal to last_grant.
  - On grant: latch addr/write/wdata onto PADDR/PWRITE/PWDATA, update last_grant, go to SETUP.
  - No valid: stay in IDLE with PSEL=0.
- SETUP (1 cycle): PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Wait for PREADY=1, which the RAM gives at the earliest one cycle after ACCESS starts.
  - On PREADY=1: capture PRDATA into the granted port's rdata on reads only (write keeps the old rdata), drop PSEL/PENABLE, go to DONE.
- DONE (1 cycle): granted reqN_done=1, reqN_err=0. The requester must deassert or change valid by the next edge. valid is ignored in DONE. Go to IDLE.
- Latency: valid sampled in cycle 0 → SETUP in cycle 1 → ACCESS in cycles 2–3 → done in cycle 4. Back-to-back throughput is one transfer per 5 cycles.
- PREADY is ignored outside ACCESS. The mandatory DONE+IDLE gap guarantees the RAM's stale PREADY has cleared before the next ACCESS.
- Round-robin: under continuous contention grants strictly alternate 0,1,0,1. A lone requester may be granted repeatedly.
- The ungranted requester's done, rdata and err are untouched.
- A valid that drops before grant is simply not serviced. Dropping valid after grant is illegal and the transfer completes anyway.

Optional Feature:
Macro APB_ARB_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. After TIMEOUT cycles with PREADY=0, the arbiter aborts: PSEL/PENABLE drop, go to DONE with reqN_done=1, reqN_err=1, reqN_rdata=0. The counter clears on entering ACCESS.
- Undefined: ACCESS waits indefinitely, the counter is absent, and reqN_err is constant 0. The ports exist in both builds.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS, DONE), grant-id typedef (1 bit), default ADDR_W/DATA_W/TIMEOUT constants.
- Sub-module rr_arb2: inputs req[1:0] and last_grant; outputs grant_valid and grant_id. Purely combinational, instantiated once. The FSM and APB registers stay in apb_ram_arbiter.

Test Plan:
- Write then read, single port: req0 write addr 0x010, data 0xDEADBEEF, then read 0x010 → PSEL rises in cycle 1, req0_done in cycle 4 each time, req0_rdata=0xDEADBEEF, req0_err=0.
- Contention: req0 and req1 both valid from reset, writing 0x11111111@0x020 and 0x22222222@0x024 → req0 is served first, then req1. Grants then alternate. Readback of both addresses returns the correct words.
- Lone requester: req1 issues 3 back-to-back reads → 3 done pulses 5 cycles apart, PSEL low in every DONE and IDLE cycle, PENABLE never high without a preceding SETUP.
- Reset mid-ACCESS: assert PRESETn=0 during req0 ACCESS → PSEL=PENABLE=0 and all outputs 0 immediately, no req0_done. After release, a req0 read is serviced normally.
- PREADY stretch: slave model holds PREADY low for 5 extra ACCESS cycles → PSEL/PENABLE held, PADDR/PWDATA stable, done one cycle after PREADY.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=16): PREADY tied 0 → after 16 ACCESS cycles req0_done=1, req0_err=1, req0_rdata=0, FSM returns to IDLE.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizes for the two-port APB RAM arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic grant_t;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// port that was not granted last.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  grant_t     last_grant,
  output logic       grant_valid,
  output grant_t     grant_id
);

  assign grant_valid = |req;
  assign grant_id    = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/apb_ram_arbiter.sv
// Shares one APB RAM slave between two requesters, one transfer at a time.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without PREADY.
module apb_ram_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PSEL,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  state_t                   r_state, w_next;
  grant_t                   r_last_grant, r_grant;
  logic                     w_gnt_valid;
  grant_t                   w_gnt_id;
  logic                     w_abort;
  logic [ADDR_W-1:0]        r_paddr;
  logic [DATA_W-1:0]        r_pwdata;
  logic                     r_pwrite, r_psel, r_penable;
  logic [1:0]               r_done, r_err;
  logic [1:0][DATA_W-1:0]   r_rdata;

  rr_arb2 u_rr (
    .req         ({req1_valid, req0_valid}),
    .last_grant  (r_last_grant),
    .grant_valid (w_gnt_valid),
    .grant_id    (w_gnt_id)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_tcnt;

  // Counts stalled ACCESS cycles; cleared on the way into ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                        r_tcnt <= '0;
    else if (r_state == SETUP)           r_tcnt <= '0;
    else if (r_state == ACCESS && !PREADY) r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_abort = (r_state == ACCESS) && !PREADY && (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (PREADY || w_abort) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs; the transfer request is captured at grant time.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pwrite     <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_done       <= '0;
      r_err        <= '0;
      r_rdata      <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_grant      <= w_gnt_id;
          r_last_grant <= w_gnt_id;
          r_paddr      <= w_gnt_id ? req1_addr  : req0_addr;
          r_pwdata     <= w_gnt_id ? req1_wdata : req0_wdata;
          r_pwrite     <= w_gnt_id ? req1_write : req0_write;
          r_psel       <= 1'b1;
          r_penable    <= 1'b0;
        end
        SETUP: r_penable <= 1'b1;
        ACCESS: if (PREADY || w_abort) begin
          r_psel           <= 1'b0;
          r_penable        <= 1'b0;
          r_done[r_grant]  <= 1'b1;
          r_err[r_grant]   <= w_abort;
          if (w_abort)        r_rdata[r_grant] <= '0;
          else if (!r_pwrite) r_rdata[r_grant] <= PRDATA;
        end
        default: ;
      endcase
    end
  end

  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;
  assign PWRITE     = r_pwrite;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign req0_done  = r_done[0];
  assign req1_done  = r_done[1];
  assign req0_err   = r_err[0];
  assign req1_err   = r_err[1];
  assign req0_rdata = r_rdata[0];
  assign req1_rdata = r_rdata[1];

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Scoreboard bench for apb_ram_arbiter with a behavioural APB RAM slave.
module tb_apb_ram_arbiter;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [11:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_done, req1_done, req0_err, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [11:0] PADDR;
  logic        PWRITE, PENABLE, PSEL, PREADY;
  logic [31:0] PWDATA, PRDATA;

  apb_ram_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // APB RAM slave: PREADY comes extra_wait cycles after the first ACCESS cycle.
  logic [31:0] mem [0:1023];
  int  extra_wait = 0, wcnt = 0;
  bit  stall = 1'b0;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY <= 1'b0; PRDATA <= '0; wcnt <= 0;
    end else if (stall) begin
      PREADY <= 1'b0; wcnt <= 0;
    end else if (PSEL && PENABLE && !PREADY) begin
      if (wcnt >= extra_wait) begin
        PREADY <= 1'b1; wcnt <= 0;
        if (PWRITE) mem[PADDR[11:2]] <= PWDATA;
        else        PRDATA <= mem[PADDR[11:2]];
      end else wcnt <= wcnt + 1;
    end else PREADY <= 1'b0;
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [31:0] m_rd;
  logic        m_err, m_done;

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge PCLK) begin
    for (int p = 0; p < 2; p++) begin
      m_done = (p == 0) ? req0_done  : req1_done;
      m_rd   = (p == 0) ? req0_rdata : req1_rdata;
      m_err  = (p == 0) ? req0_err   : req1_err;
      if (m_done) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done port=%0d cyc=%0d", p, cyc);
        end else begin
          me = sb.pop_front();
          if (me.port != p || me.rdata !== m_rd || me.err !== m_err || me.cyc != cyc) begin
            n_fail++;
            $display("FAIL done_check got port=%0d rdata=%h err=%b cyc=%0d, expected port=%0d rdata=%h err=%b cyc=%0d",
                     p, m_rd, m_err, cyc, me.port, me.rdata, me.err, me.cyc);
          end
        end
      end
    end
  end

  // APB protocol watcher.
  logic        pv_psel = 0, pv_pen = 0, pv_rdy = 0, pv_done = 0, pv_wr = 0;
  logic [11:0] pv_addr = '0;
  logic [31:0] pv_wdata = '0;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (PENABLE && !pv_pen) begin
        n_chk++;
        if (!(pv_psel && PSEL)) begin
          n_fail++; $display("FAIL penable_without_setup got prev_psel=%b psel=%b, expected 1 1", pv_psel, PSEL);
        end
      end
      if (PENABLE && pv_pen && !pv_rdy) begin
        n_chk++;
        if (!PSEL || PADDR !== pv_addr || PWDATA !== pv_wdata || PWRITE !== pv_wr) begin
          n_fail++; $display("FAIL access_stable got addr=%h wdata=%h, expected addr=%h wdata=%h", PADDR, PWDATA, pv_addr, pv_wdata);
        end
      end
      if (req0_done || req1_done || pv_done) begin
        n_chk++;
        if (PSEL || PENABLE) begin
          n_fail++; $display("FAIL psel_in_done_idle got psel=%b penable=%b, expected 0 0", PSEL, PENABLE);
        end
      end
    end
    pv_psel = PSEL; pv_pen = PENABLE; pv_rdy = PREADY; pv_done = req0_done | req1_done;
    pv_addr = PADDR; pv_wdata = PWDATA; pv_wr = PWRITE;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_apb"}, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req0_done, req1_done, req0_err, req1_err}, '0);
    chk({nm, "_rdata0"}, req0_rdata, '0);
    chk({nm, "_rdata1"}, req1_rdata, '0);
  endtask

  task automatic push(input int p, input logic [31:0] rd, input logic er, input int c);
    exp_t e;
    e.port = p; e.rdata = rd; e.err = er; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drive(input int p, input logic wr, input logic [11:0] ad, input logic [31:0] wd);
    int n;
    logic d;
    if (p == 0) begin req0_valid = 1; req0_write = wr; req0_addr = ad; req0_wdata = wd; end
    else        begin req1_valid = 1; req1_write = wr; req1_addr = ad; req1_wdata = wd; end
    n = 0;
    do begin
      @(negedge PCLK); n++;
      d = (p == 0) ? req0_done : req1_done;
    end while (!d && n < 200);
    if (!d) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done port=%0d got no done in 200 cycles, expected done", p);
    end
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  int base;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 chk_zero("reset");
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Contention from reset: 0 wins first, then strict alternation
    @(posedge PCLK); #1 base = cyc;
    push(0, 32'h0,        1'b0, base + 4);
    push(1, 32'h0,        1'b0, base + 9);
    push(0, 32'h22222222, 1'b0, base + 14);
    push(1, 32'h11111111, 1'b0, base + 19);
    fork
      begin drive(0, 1, 12'h020, 32'h11111111); drive(0, 0, 12'h024, 32'h0); end
      begin drive(1, 1, 12'h024, 32'h22222222); drive(1, 0, 12'h020, 32'h0); end
    join

    // Single port write then read; write keeps old rdata
    @(posedge PCLK); #1 base = cyc;
    push(0, 32'h22222222, 1'b0, base + 4);
    push(0, 32'hDEADBEEF, 1'b0, base + 9);
    fork
      begin drive(0, 1, 12'h010, 32'hDEADBEEF); drive(0, 0, 12'h010, 32'h0); end
      begin
        @(negedge PCLK) chk("idle_c0", {PSEL, PENABLE}, 2'b00);
        @(negedge PCLK) chk("setup_c1", {PSEL, PENABLE}, 2'b10);
        @(negedge PCLK) chk("access_c2", {PSEL, PENABLE, PADDR}, {2'b11, 12'h010});
      end
    join

    // Lone requester, back-to-back reads
    @(posedge PCLK); #1 base = cyc;
    push(1, 32'hDEADBEEF, 1'b0, base + 4);
    push(1, 32'h11111111, 1'b0, base + 9);
    push(1, 32'h22222222, 1'b0, base + 14);
    drive(1, 0, 12'h010, 32'h0);
    drive(1, 0, 12'h020, 32'h0);
    drive(1, 0, 12'h024, 32'h0);

    // Reset during ACCESS: transfer dropped, no done
    @(posedge PCLK); #1 base = cyc;
    req0_valid = 1; req0_write = 0; req0_addr = 12'h020;
    repeat (3) @(negedge PCLK);
    chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #1 PRESETn = 1'b0;
    #1 chk_zero("mid_reset");
    repeat (2) @(posedge PCLK);
    #1 req0_valid = 0; PRESETn = 1'b1;
    @(posedge PCLK); #1 base = cyc;
    push(0, 32'hDEADBEEF, 1'b0, base + 4);
    drive(0, 0, 12'h010, 32'h0);

    // PREADY stretched by 5 cycles
    @(posedge PCLK); #1 base = cyc;
    extra_wait = 5;
    push(0, 32'hDEADBEEF, 1'b0, base + 9);
    push(0, 32'hCAFEF00D, 1'b0, base + 14);
    drive(0, 1, 12'h030, 32'hCAFEF00D);
    extra_wait = 0;
    drive(0, 0, 12'h030, 32'h0);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never answers: abort after 16 ACCESS cycles
    @(posedge PCLK); #1 base = cyc;
    stall = 1'b1;
    push(0, 32'h0,        1'b1, base + 18);
    push(0, 32'hCAFEF00D, 1'b0, base + 23);
    drive(0, 0, 12'h010, 32'h0);
    stall = 1'b0;
    drive(0, 0, 12'h030, 32'h0);
`endif

    repeat (6) @(negedge PCLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
